// File: rtl/unit_pkt_tx.sv
// Serializes one job descriptor into the unit byte stream (header, fields, key, trailer) or a single init word.
// Latency: each byte is registered one cycle after unit_out_afull is seen low; afull holds the byte index so the byte is retried.
// Backpressure: in_ready only in IDLE; UNIT_PKT_TX_FIXED_KEY_EN pads the key field to MAX_KEY_LEN bytes.
module unit_pkt_tx #(
  parameter int MAX_KEY_LEN = 64,
  parameter int SALT_BYTES  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_type,
  input  logic [4:0]               init_data,
  input  logic [31:0]              cnt,
  input  logic [7:0]               salt_len,
  input  logic [SALT_BYTES*8-1:0]  salt,
  input  logic [63:0]              ids,
  input  logic [7:0]               key_len,
  input  logic [MAX_KEY_LEN*8-1:0] key,
  output logic [7:0]               unit_out,
  output logic                     unit_out_ctrl,
  output logic                     unit_out_wr_en,
  input  logic                     unit_out_afull,
  input  logic                     unit_ready,
  output logic                     idle,
  output logic                     err_key_len
);

  localparam int         KIW    = $clog2(MAX_KEY_LEN);
  localparam int         SIW    = $clog2(SALT_BYTES);
  localparam logic [7:0] MAX_KL = 8'(MAX_KEY_LEN);
  localparam logic [7:0] SALT_N = 8'(SALT_BYTES);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_HDR, S_CNT, S_SLEN, S_SALT, S_IDS, S_KLEN, S_KEY, S_TRL, S_INIT
  } state_t;

  state_t     state_q, state_d, nxt;
  logic [7:0] idx_q, idx_d, len, byte_d;
  logic       ctrl_d, wr_en_d, emit, accept;

  logic [7:0] cnt_b  [4];
  logic [7:0] salt_b [SALT_BYTES];
  logic [7:0] ids_b  [8];
  logic [7:0] key_b  [MAX_KEY_LEN];
  logic [7:0] salt_len_q, klen_q, kbytes_q;
  logic [4:0] init_q;
  logic [7:0] key_len_c, key_bytes_c;

  assign accept    = (state_q == S_IDLE) && in_valid;
  assign in_ready  = (state_q == S_IDLE);
  assign idle      = (state_q == S_IDLE);
  assign key_len_c = (key_len > MAX_KL) ? MAX_KL : key_len;
`ifdef UNIT_PKT_TX_FIXED_KEY_EN
  assign key_bytes_c = MAX_KL;
`else
  assign key_bytes_c = (key_len_c + 8'd3) & 8'hFC;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nxt     = state_q;
    len     = 8'd1;
    byte_d  = 8'h00;
    ctrl_d  = 1'b0;
    emit    = 1'b0;
    wr_en_d = 1'b0;
    case (state_q)
      S_IDLE:     if (in_valid) state_d = in_type ? S_INIT : S_WAIT_RDY;
      S_WAIT_RDY: if (unit_ready) state_d = S_HDR;
      S_HDR:  begin emit = 1'b1; ctrl_d = 1'b1; nxt = S_CNT; end
      S_CNT:  begin emit = 1'b1; byte_d = cnt_b[idx_q[1:0]]; len = 8'd4; nxt = S_SLEN; end
      S_SLEN: begin
        emit = 1'b1; len = 8'd4; nxt = S_SALT;
        byte_d = (idx_q == 8'd0) ? salt_len_q : 8'h00;
      end
      S_SALT: begin emit = 1'b1; byte_d = salt_b[idx_q[SIW-1:0]]; len = SALT_N; nxt = S_IDS; end
      S_IDS:  begin emit = 1'b1; byte_d = ids_b[idx_q[2:0]]; len = 8'd8; nxt = S_KLEN; end
      S_KLEN: begin
        emit = 1'b1; len = 8'd8;
        byte_d = (idx_q == 8'd0) ? klen_q : 8'h00;
        nxt = (kbytes_q == 8'd0) ? S_TRL : S_KEY;
      end
      // Padding beyond the clamped key length goes out as zeros.
      S_KEY: begin
        emit = 1'b1; len = kbytes_q; nxt = S_TRL;
        byte_d = (idx_q < klen_q) ? key_b[idx_q[KIW-1:0]] : 8'h00;
      end
      S_TRL:  begin emit = 1'b1; ctrl_d = 1'b1; nxt = S_IDLE; end
      S_INIT: begin emit = 1'b1; ctrl_d = 1'b1; byte_d = {init_q, 3'b001}; nxt = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
    if (emit && !unit_out_afull) begin
      wr_en_d = 1'b1;
      if (idx_q == len - 8'd1) begin
        idx_d   = 8'd0;
        state_d = nxt;
      end else begin
        idx_d = idx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      idx_q          <= 8'd0;
      unit_out       <= 8'h00;
      unit_out_ctrl  <= 1'b0;
      unit_out_wr_en <= 1'b0;
      err_key_len    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      unit_out_wr_en <= wr_en_d;
      unit_out_ctrl  <= wr_en_d & ctrl_d;
      if (wr_en_d) unit_out <= byte_d;
      if (accept && (key_len > MAX_KL)) err_key_len <= 1'b1;
    end
  end

  // Descriptor capture; contents are only consumed after acceptance.
  always_ff @(posedge CLK) begin
    if (accept) begin
      salt_len_q <= salt_len;
      klen_q     <= key_len_c;
      kbytes_q   <= key_bytes_c;
      init_q     <= init_data;
      for (int i = 0; i < 4; i++)           cnt_b[i]  <= cnt[8*i +: 8];
      for (int i = 0; i < SALT_BYTES; i++)  salt_b[i] <= salt[8*i +: 8];
      for (int i = 0; i < 8; i++)           ids_b[i]  <= ids[8*i +: 8];
      for (int i = 0; i < MAX_KEY_LEN; i++) key_b[i]  <= key[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_unit_pkt_tx.sv
// Directed bench for unit_pkt_tx: captures every written word and compares against hand values and a packet model.
module tb_unit_pkt_tx;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_valid, in_ready, in_type;
  logic [4:0]   init_data;
  logic [31:0]  cnt;
  logic [7:0]   salt_len, key_len;
  logic [127:0] salt;
  logic [63:0]  ids;
  logic [511:0] key;
  logic [7:0]   unit_out;
  logic         unit_out_ctrl, unit_out_wr_en;
  logic         unit_out_afull = 1'b0;
  logic         unit_ready;
  logic         idle, err_key_len;

  always #5 CLK = ~CLK;

  unit_pkt_tx dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .init_data(init_data), .cnt(cnt), .salt_len(salt_len), .salt(salt), .ids(ids),
    .key_len(key_len), .key(key), .unit_out(unit_out), .unit_out_ctrl(unit_out_ctrl),
    .unit_out_wr_en(unit_out_wr_en), .unit_out_afull(unit_out_afull),
    .unit_ready(unit_ready), .idle(idle), .err_key_len(err_key_len)
  );

`ifdef UNIT_PKT_TX_FIXED_KEY_EN
  localparam int LEN_K8 = 106, LEN_K5 = 106, LEN_K48 = 106;
`else
  localparam int LEN_K8 = 50, LEN_K5 = 50, LEN_K48 = 90;
`endif

  int         n_tests = 0, n_fail = 0, cyc = 0;
  int         stall_at = -1;
  int         stall_cnt = 0;
  logic [8:0] got_q[$];
  int         got_cyc[$];
  logic [8:0] exp_q[$];

  // Capture writes; also drives afull for the stall scenario.
  always @(negedge CLK) begin
    cyc++;
    if (stall_cnt > 0) begin
      stall_cnt--;
      if (stall_cnt == 0) unit_out_afull = 1'b0;
    end
    if (unit_out_wr_en) begin
      got_q.push_back({unit_out_ctrl, unit_out});
      got_cyc.push_back(cyc);
      if (got_q.size() == stall_at) begin
        unit_out_afull = 1'b1;
        stall_cnt = 5;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic typ, input logic [4:0] idat, input logic [31:0] c,
                      input logic [7:0] sl, input logic [127:0] s, input logic [63:0] id,
                      input logic [7:0] kl, input logic [511:0] k);
    int t = 0;
    while (!in_ready && t < 500) begin @(negedge CLK); t++; end
    check("accept_ready", in_ready, 1'b1);
    in_type = typ; init_data = idat; cnt = c; salt_len = sl; salt = s; ids = id;
    key_len = kl; key = k; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    in_type = ~typ; init_data = 5'h1F; cnt = 32'hDEADBEEF; salt_len = 8'hEE;
    salt = '1; ids = '1; key_len = 8'hFF; key = '1;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge CLK); t++; end while (!idle && t < 1000);
    check("done_idle", idle, 1'b1);
    @(negedge CLK);
  endtask

  task automatic build_exp(input logic [31:0] c, input logic [7:0] sl, input logic [127:0] s,
                           input logic [63:0] id, input logic [7:0] kl, input logic [511:0] k);
    int lc, kb;
    exp_q.delete();
    lc = (kl > 64) ? 64 : int'(kl);
`ifdef UNIT_PKT_TX_FIXED_KEY_EN
    kb = 64;
`else
    kb = ((lc + 3) / 4) * 4;
`endif
    exp_q.push_back(9'h100);
    for (int i = 0; i < 4; i++)  exp_q.push_back({1'b0, c[8*i +: 8]});
    exp_q.push_back({1'b0, sl});
    for (int i = 0; i < 3; i++)  exp_q.push_back(9'h000);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, s[8*i +: 8]});
    for (int i = 0; i < 8; i++)  exp_q.push_back({1'b0, id[8*i +: 8]});
    exp_q.push_back({1'b0, 8'(lc)});
    for (int i = 0; i < 7; i++)  exp_q.push_back(9'h000);
    for (int i = 0; i < kb; i++) exp_q.push_back((i < lc) ? {1'b0, k[8*i +: 8]} : 9'h000);
    exp_q.push_back(9'h100);
  endtask

  task automatic cmp_pkt(input int base, input string tag);
    check({tag, "_len"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size())
        check($sformatf("%s_w%0d", tag, i), got_q[base + i], exp_q[i]);
  endtask

  initial begin
    logic [127:0] salt1;
    logic [63:0]  ids1;
    logic [511:0] key1, key2;
    int base, n, t;

    for (int k = 0; k < 16; k++) salt1[8*k +: 8] = (k < 8) ? 8'h73 : 8'(8'hA0 + k);
    for (int k = 0; k < 64; k++) key1[8*k +: 8] = (k < 8) ? 8'h31 : 8'(8'h80 + k);
    for (int k = 0; k < 64; k++) key2[8*k +: 8] = 8'(8'h80 + k);
    ids1 = 64'h1817161514131211;

    RST = 1'b1; in_valid = 1'b0; in_type = 1'b0; init_data = '0; cnt = '0; salt_len = '0;
    salt = '0; ids = '0; key_len = '0; key = '0; unit_ready = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_wr_en", unit_out_wr_en, 1'b0);
    check("rst_ctrl", unit_out_ctrl, 1'b0);
    check("rst_out", unit_out, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_idle", idle, 1'b1);
    check("rst_err", err_key_len, 1'b0);
    RST = 1'b0;
    @(negedge CLK);

    // Basic packet.
    base = got_q.size();
    send(1'b0, 5'd0, 32'd10, 8'd8, salt1, ids1, 8'd8, key1);
    wait_idle();
    check("basic_total", got_q.size() - base, LEN_K8);
    check("basic_w0", got_q[base], 9'h100);
    check("basic_w1", got_q[base + 1], 9'h00A);
    check("basic_w2", got_q[base + 2], 9'h000);
    check("basic_w5", got_q[base + 5], 9'h008);
    check("basic_w41", got_q[base + 41], 9'h031);
    check("basic_last_ctrl", got_q[got_q.size() - 1], 9'h100);
    build_exp(32'd10, 8'd8, salt1, ids1, 8'd8, key1);
    cmp_pkt(base, "basic");

    // afull stall on salt byte 3.
    base = got_q.size();
    stall_at = base + 12;
    send(1'b0, 5'd0, 32'd10, 8'd8, salt1, ids1, 8'd8, key1);
    wait_idle();
    stall_at = -1;
    check("stall_total", got_q.size() - base, LEN_K8);
    check("stall_gap", got_cyc[base + 12] - got_cyc[base + 11], 6);
    check("stall_resume_byte", got_q[base + 12], 9'h073);
    cmp_pkt(base, "stall");

    // key_len = 5: padded to 8.
    base = got_q.size();
    send(1'b0, 5'd0, 32'h04030201, 8'd3, salt1, ids1, 8'd5, key2);
    wait_idle();
    check("k5_total", got_q.size() - base, LEN_K5);
    check("k5_klen", got_q[base + 33], 9'h005);
    check("k5_byte4", got_q[base + 45], 9'h084);
    check("k5_byte5", got_q[base + 46], 9'h000);
    build_exp(32'h04030201, 8'd3, salt1, ids1, 8'd5, key2);
    cmp_pkt(base, "k5");

    // key_len = 48.
    base = got_q.size();
    send(1'b0, 5'd0, 32'd7, 8'd16, salt1, ids1, 8'd48, key2);
    wait_idle();
    check("k48_total", got_q.size() - base, LEN_K48);
    check("k48_err", err_key_len, 1'b0);
    build_exp(32'd7, 8'd16, salt1, ids1, 8'd48, key2);
    cmp_pkt(base, "k48");

    // key_len = 65: clamped and flagged.
    base = got_q.size();
    send(1'b0, 5'd0, 32'd1, 8'd0, salt1, ids1, 8'd65, key2);
    wait_idle();
    check("k65_err", err_key_len, 1'b1);
    check("k65_total", got_q.size() - base, 106);
    check("k65_klen", got_q[base + 33], 9'h040);
    check("k65_key63", got_q[base + 104], 9'h0BF);
    build_exp(32'd1, 8'd0, salt1, ids1, 8'd65, key2);
    cmp_pkt(base, "k65");

    // Init packet ignores unit_ready.
    unit_ready = 1'b0;
    base = got_q.size();
    send(1'b1, 5'd1, 32'd0, 8'd0, salt1, ids1, 8'd0, key2);
    wait_idle();
    check("init_total", got_q.size() - base, 1);
    check("init_word", got_q[base], 9'h109);

    // Data packet waits for unit_ready.
    base = got_q.size();
    send(1'b0, 5'd0, 32'd10, 8'd8, salt1, ids1, 8'd8, key1);
    repeat (10) @(negedge CLK);
    check("wait_rdy_no_writes", got_q.size() - base, 0);
    check("wait_rdy_busy", idle, 1'b0);
    unit_ready = 1'b1;
    wait_idle();
    build_exp(32'd10, 8'd8, salt1, ids1, 8'd8, key1);
    cmp_pkt(base, "wait_rdy");

    // Reset in the middle of the key field.
    base = got_q.size();
    send(1'b0, 5'd0, 32'd2, 8'd4, salt1, ids1, 8'd64, key2);
    t = 0;
    while (got_q.size() - base < 46 && t < 500) begin @(negedge CLK); t++; end
    check("rst_mid_reached_key", got_q.size() - base >= 46, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_wr_en", unit_out_wr_en, 1'b0);
    check("rst_mid_idle", idle, 1'b1);
    check("rst_mid_in_ready", in_ready, 1'b1);
    check("rst_mid_err", err_key_len, 1'b0);
    RST = 1'b0;
    n = got_q.size();
    repeat (5) @(negedge CLK);
    check("rst_mid_no_trailer", got_q.size(), n);
    check("rst_mid_last_ctrl", got_q[n - 1][8], 1'b0);

    // Packet after the abort.
    base = got_q.size();
    send(1'b0, 5'd0, 32'd10, 8'd8, salt1, ids1, 8'd8, key1);
    wait_idle();
    check("post_rst_total", got_q.size() - base, LEN_K8);
    build_exp(32'd10, 8'd8, salt1, ids1, 8'd8, key1);
    cmp_pkt(base, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
